// File: rtl/alu_seq_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_acc_if
// Description : Start/busy/done handshake and operand/result bus of the
//               sequential accumulator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_acc_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 use_acc;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 carry;
    logic                 zero;

    modport master (
        output start, op, a, b, use_acc,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, a, b, use_acc,
        output busy, done, result, carry, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_acc.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_acc
// Description : Registered ALU with accumulator feedback, start/busy/done
//               handshake and a WIDTH-cycle shift-add multiplier.
//               Define ALU_SAT_EN for saturating add/increment/subtract.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_acc #(
    parameter int WIDTH = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    alu_seq_acc_if.slave  bus
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(RW);
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [RW-1:0]      mcand_q, mcand_d;
    logic [RW-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]      result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum_inc, sum_add, diff;
    logic [RW-1:0]      ext_a, mul_sum;
    logic [RW-1:0]      alu_res;
    logic               alu_carry;

    assign sum_inc = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_add = {1'b0, a_q} + {1'b0, b_q};
    // MSB of the extended difference is the borrow (set exactly when A < B).
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    assign ext_a   = {{WIDTH{1'b0}}, a_q};
    assign mul_sum = prod_q + (b_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res   = RW'(sum_inc);
                alu_carry = sum_inc[WIDTH];
            end
            3'b001: begin
                alu_res   = RW'(sum_add);
                alu_carry = sum_add[WIDTH];
            end
            3'b010: begin
                alu_res   = RW'(diff[WIDTH-1:0]);
                alu_carry = diff[WIDTH];
            end
            3'b011: alu_res = {a_q | b_q, a_q ^ b_q};
            3'b100: alu_res = RW'(|{a_q, b_q});
            3'b101: alu_res = {a_q, b_q};
            3'b110: alu_res = ({1'b0, b_q} >= SHIFT_LIM) ? '0 : (ext_a << b_q);
            3'b111: alu_res = '0;  // multiply completes in S_MUL
        endcase
        if (SAT && alu_carry) begin
            if (op_q == 3'b000 || op_q == 3'b001) begin
                alu_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            end else if (op_q == 3'b010) begin
                alu_res = '0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.use_acc ? result_q[WIDTH-1:0] : bus.b;
                    mcand_d = RW'(bus.a);
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = (bus.op == 3'b111) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                carry_d  = alu_carry;
                zero_d   = (alu_res == '0);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_MUL: begin
                // b_q doubles as the multiplier shift register, LSB first.
                prod_d  = mul_sum;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = mul_sum;
                    carry_d  = 1'b0;
                    zero_d   = (mul_sum == '0);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_acc
// Description : Self-checking bench for alu_seq_acc (WIDTH=4); honours ALU_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_acc;
    localparam int WIDTH = 4;
    localparam int RW    = 2 * WIDTH;
    localparam int NVEC  = 18;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    alu_seq_acc_if #(.WIDTH(WIDTH)) bus ();
    alu_seq_acc #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             use_acc;
        logic [RW-1:0]    res;
        logic             carry;
    } vec_t;

    typedef struct {
        logic [RW-1:0] res;
        logic          carry;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[NVEC];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding operation.
    always @(negedge clock) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", RW'(bus.done), '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("carry", RW'(bus.carry), RW'(e.carry));
                check("zero", RW'(bus.zero), RW'(e.res == '0));
                check("latency", RW'(cyc), RW'(e.cyc));
            end
        end
    end

    // Called at a negedge with busy low; returns at the negedge busy falls.
    task automatic issue(input vec_t v);
        int busy_cnt;
        busy_cnt    = 0;
        bus.start   = 1'b1;
        bus.op      = v.op;
        bus.a       = v.a;
        bus.b       = v.b;
        bus.use_acc = v.use_acc;
        sb.push_back('{v.res, v.carry, cyc + ((v.op == 3'b111) ? WIDTH + 1 : 2)});
        @(negedge clock);
        bus.start = 1'b0;
        while (bus.busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            @(negedge clock);
        end
        check("busy_cycles", RW'(busy_cnt), RW'((v.op == 3'b111) ? WIDTH : 1));
    endtask

    initial begin
        int dcnt;
        int guard;
        vecs[0]  = '{3'b001, 4'd9,  4'd8,  1'b0, SAT ? 8'h0F : 8'h11, 1'b1};
        vecs[1]  = '{3'b001, 4'd3,  4'd4,  1'b0, 8'h07, 1'b0};
        vecs[2]  = '{3'b001, 4'd5,  4'd0,  1'b1, 8'h0C, 1'b0};
        vecs[3]  = '{3'b111, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0};
        vecs[4]  = '{3'b111, 4'd0,  4'd13, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{3'b010, 4'd2,  4'd5,  1'b0, SAT ? 8'h00 : 8'h0D, 1'b1};
        vecs[6]  = '{3'b110, 4'd1,  4'd7,  1'b0, 8'h80, 1'b0};
        vecs[7]  = '{3'b110, 4'd1,  4'd8,  1'b0, 8'h00, 1'b0};
        vecs[8]  = '{3'b011, 4'hA,  4'h6,  1'b0, 8'hEC, 1'b0};
        vecs[9]  = '{3'b100, 4'd0,  4'd0,  1'b0, 8'h00, 1'b0};
        vecs[10] = '{3'b000, 4'd15, 4'd0,  1'b0, SAT ? 8'h0F : 8'h10, 1'b1};
        vecs[11] = '{3'b101, 4'h3,  4'hC,  1'b0, 8'h3C, 1'b0};
        vecs[12] = '{3'b100, 4'd0,  4'd2,  1'b0, 8'h01, 1'b0};
        vecs[13] = '{3'b010, 4'd7,  4'd3,  1'b0, 8'h04, 1'b0};
        vecs[14] = '{3'b111, 4'd13, 4'd11, 1'b0, 8'h8F, 1'b0};
        vecs[15] = '{3'b111, 4'd2,  4'd0,  1'b1, 8'h1E, 1'b0};
        vecs[16] = '{3'b110, 4'd5,  4'd3,  1'b0, 8'h28, 1'b0};
        vecs[17] = '{3'b000, 4'd3,  4'd9,  1'b0, 8'h04, 1'b0};

        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.use_acc = 1'b0;

        @(negedge clock);
        check("rst_busy",   RW'(bus.busy),  '0);
        check("rst_done",   RW'(bus.done),  '0);
        check("rst_result", bus.result,     '0);
        check("rst_carry",  RW'(bus.carry), '0);
        check("rst_zero",   RW'(bus.zero),  RW'(1));
        reset = 1'b0;
        @(negedge clock);

        // Back-to-back: each issue starts in the cycle done is high.
        for (int i = 0; i < NVEC; i++) issue(vecs[i]);

        // Start pulse during a multiply must be dropped, not queued.
        bus.start = 1'b1; bus.op = 3'b111; bus.a = 4'd15; bus.b = 4'd15; bus.use_acc = 1'b0;
        sb.push_back('{8'hE1, 1'b0, cyc + WIDTH + 1});
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'b000; bus.a = 4'd1; bus.b = 4'd0;
        @(negedge clock);
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin guard++; @(negedge clock); end
        check("ignored_wait", RW'(guard < 40), RW'(1));
        repeat (4) @(negedge clock);
        check("result_hold", bus.result, 8'hE1);

        // Asynchronous reset two cycles into a multiply.
        bus.start = 1'b1; bus.op = 3'b111; bus.a = 4'd15; bus.b = 4'd15;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy",   RW'(bus.busy), '0);
        check("midrst_result", bus.result,    '0);
        check("midrst_zero",   RW'(bus.zero), RW'(1));
        check("midrst_done",   RW'(bus.done), '0);
        @(negedge clock);
        reset = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.done === 1'b1) dcnt++;
        end
        check("done_after_reset", RW'(dcnt), '0);

        // Recovery: accumulator starts from the cleared result.
        issue('{3'b001, 4'd6, 4'd0, 1'b1, 8'h06, 1'b0});
        repeat (3) @(negedge clock);
        check("sb_drained", RW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
